// File: rtl/team_06_spi_pkg.sv
// rtl/team_06_spi_pkg.sv - shared types and constants for the SPI transmit serializer
package team_06_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;
  localparam int ORDER_LSB = 0;
  localparam int ORDER_MSB = 1;

  function automatic logic edge_detect(input logic rise_sel, input logic now, input logic prev);
    return rise_sel ? (now & ~prev) : (~now & prev);
  endfunction

endpackage

// File: rtl/team_06_spi_tx_serializer_if.sv
// rtl/team_06_spi_tx_serializer_if.sv - word handshake into the serializer FIFO
interface team_06_spi_tx_serializer_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/team_06_sync_fifo.sv
// rtl/team_06_sync_fifo.sv - single-clock FIFO, registered count, no fall-through
module team_06_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/team_06_spi_tx_serializer.sv
// rtl/team_06_spi_tx_serializer.sv - buffered SPI transmit serializer with generated chip select
module team_06_spi_tx_serializer
  import team_06_spi_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int MSB_FIRST     = ORDER_MSB,
  parameter int SHIFT_ON_RISE = EDGE_FALL,
  parameter int CONT_FRAME    = 1,
  parameter int GAP_CYC       = 2,
  localparam int CW           = $clog2(FIFO_DEPTH + 1),
  localparam int BW           = $clog2(DATA_W),
  localparam int GW           = $clog2(GAP_CYC + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          spiclk,
  input  logic                          enable,
  team_06_spi_tx_serializer_if.slave    stream,
  output logic                          cs,
  output logic                          serial_out,
  output logic                          busy,
  output logic                          frame_done,
  output logic [CW-1:0]                 fifo_count
);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic [DATA_W-1:0] head;
  logic [BW-1:0]     bit_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              spiclk_q;
  logic              shift_edge;
  logic              last_bit;
  logic              head_first;
  logic              next_bit;
  logic              full;
  logic              empty;
  logic              pop;

  team_06_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (stream.s_valid),
    .push_data (stream.s_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign stream.s_ready = ~full;

  assign shift_edge = edge_detect(SHIFT_ON_RISE != 0, spiclk, spiclk_q);
  assign last_bit   = (bit_cnt == BW'(DATA_W - 1));

  // The shift register always presents the next bit to send at the end nearest the output.
  assign head_first = (MSB_FIRST != 0) ? head[DATA_W-1]  : head[0];
  assign next_bit   = (MSB_FIRST != 0) ? shreg[DATA_W-2] : shreg[1];
  assign shreg_next = (MSB_FIRST != 0) ? {shreg[DATA_W-2:0], 1'b0}
                                       : {1'b0, shreg[DATA_W-1:1]};

  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = enable & ~empty;
      SHIFT:   pop = shift_edge & last_bit & (CONT_FRAME != 0) & enable & ~empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      spiclk_q   <= 1'b0;
      cs         <= 1'b1;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      spiclk_q   <= spiclk;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          cs         <= 1'b1;
          serial_out <= 1'b0;
          if (pop) begin
            shreg      <= head;
            serial_out <= head_first;
            cs         <= 1'b0;
            bit_cnt    <= '0;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_edge) begin
            if (!last_bit) begin
              bit_cnt    <= bit_cnt + 1'b1;
              shreg      <= shreg_next;
              serial_out <= next_bit;
            end else if (pop) begin
              shreg      <= head;
              serial_out <= head_first;
              bit_cnt    <= '0;
            end else begin
              cs         <= 1'b1;
              serial_out <= 1'b0;
              frame_done <= 1'b1;
              gap_cnt    <= '0;
              state      <= GAP;
            end
          end
        end
        GAP: begin
          cs <= 1'b1;
          if (gap_cnt == GW'(GAP_CYC - 1)) begin
            gap_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          cs         <= 1'b1;
          serial_out <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
